// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution accumulate path.
// Row-group selects and default datapath widths live here.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  localparam logic [1:0] SEL_ROW0 = 2'd0;
  localparam logic [1:0] SEL_ROW1 = 2'd1;
  localparam logic [1:0] SEL_ROW2 = 2'd2;

  localparam int TAPS_PER_SEL = 3;
  localparam int NUM_SEL      = 3;

  localparam int DEF_ACC_W = 18;
  localparam int DEF_OUT_W = 8;

endpackage

// File: rtl/conv_accum_seq_if.sv
// Window/result handshake bundle between the accumulate stage,
// its upstream window source, the compute block and downstream.
interface conv_accum_seq_if
  import conv_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic             win_valid;
  logic             win_last;
  logic             win_ready;
  logic [1:0]       select;
  logic [15:0]      sum;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic [ACC_W-1:0] res_raw;
  logic             res_last;

  modport master (
    output win_valid,
    output win_last,
    output sum,
    output res_ready,
    input  win_ready,
    input  select,
    input  res_valid,
    input  res_data,
    input  res_raw,
    input  res_last
  );

  modport slave (
    input  win_valid,
    input  win_last,
    input  sum,
    input  res_ready,
    output win_ready,
    output select,
    output res_valid,
    output res_data,
    output res_raw,
    output res_last
  );

endinterface

// File: rtl/conv_accum_seq_sat_shift.sv
// Unsigned right shift followed by saturation to OUT_W bits.
// Shared with the pooling and activation stages.
module sat_shift #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  logic [IN_W-1:0] sh;

  assign sh = din >> SHIFT;

  generate
    if (OUT_W < IN_W) begin : g_sat
      assign dout = (|sh[IN_W-1:OUT_W]) ? '1 : sh[OUT_W-1:0];
    end else begin : g_ext
      assign dout = OUT_W'(sh);
    end
  endgenerate

endmodule

// File: rtl/conv_accum_seq.sv
// Sequences the compute block through its three row groups and
// accumulates the partial sums into one scaled 3x3 result.
module conv_accum_seq
  import conv_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = 0
) (
  input logic             clk,
  input logic             rst_n,
  conv_accum_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= SEL_ROW0;
      acc_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    last_d  = last_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.win_valid) begin
          state_d = MAC;
          cnt_d   = SEL_ROW0;
          last_d  = bus.win_last;
        end
      end
      (state_q == MAC): begin
        // first row group restarts the sum, dropping the old result
        if (cnt_q == SEL_ROW0) begin
          acc_d = ACC_W'(bus.sum);
        end else begin
          acc_d = acc_q + ACC_W'(bus.sum);
        end
        if (cnt_q == SEL_ROW2) begin
          state_d = OUT;
          cnt_d   = SEL_ROW0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      (state_q == OUT): begin
        if (bus.res_ready) begin
          if (bus.win_valid) begin
            state_d = MAC;
            cnt_d   = SEL_ROW0;
            last_d  = bus.win_last;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = SEL_ROW0;
      end
    endcase
  end

  assign bus.win_ready = (state_q == MAC) && (cnt_q == SEL_ROW2);
  assign bus.select    = (state_q == MAC) ? cnt_q : SEL_ROW0;
  assign bus.res_valid = (state_q == OUT);
  assign bus.res_raw   = acc_q;
  assign bus.res_last  = last_q;

  sat_shift #(
    .IN_W (ACC_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_sat (
    .din (acc_q),
    .dout(bus.res_data)
  );

endmodule
